// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// pipeline-depth helpers used by both the RTL and its bench.
package shift_pkg;

    localparam int unsigned OP_LEN   = 3;
    localparam int unsigned WORD_LEN = 32;

    typedef enum logic [OP_LEN-1:0] {
        SHIFT_SLL = 3'b000,
        SHIFT_SRL = 3'b001,
        SHIFT_SRA = 3'b010,
        SHIFT_ROL = 3'b011,
        SHIFT_ROR = 3'b100
    } shift_op_e;

    // Ceiling log2; the amount of shamt bits, i.e. cascaded levels, for a width.
    function automatic int unsigned shift_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Register stages: one slice per REG_EVERY levels, plus one for any remainder.
    function automatic int unsigned shift_lat(input int unsigned data_len,
                                              input int unsigned reg_every);
        return (shift_clog2(data_len) + reg_every - 1) / reg_every;
    endfunction

    function automatic logic op_reserved(input logic [OP_LEN-1:0] op);
        return op > 3'(SHIFT_ROR);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts or rotates by SHIFT_NUM when en is set.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned DATA_LEN  = 64,
    parameter int unsigned SHIFT_NUM = 1
) (
    input  logic [OP_LEN-1:0]   op,
    input  logic                en,
    input  logic [DATA_LEN-1:0] data,
    output logic [DATA_LEN-1:0] result_c
);

    always_comb begin
        result_c = data;
        if (en) begin
            case (op)
                SHIFT_SLL: result_c = data << SHIFT_NUM;
                SHIFT_SRL: result_c = data >> SHIFT_NUM;
                SHIFT_SRA: result_c = DATA_LEN'($signed(data) >>> SHIFT_NUM);
                SHIFT_ROL: result_c = (data << SHIFT_NUM) | (data >> (DATA_LEN - SHIFT_NUM));
                SHIFT_ROR: result_c = (data >> SHIFT_NUM) | (data << (DATA_LEN - SHIFT_NUM));
                default:   result_c = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready flow control, RV64 word mode and
// an opaque routing tag; a register slice follows every REG_EVERY levels.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DATA_LEN   = 64,
    parameter int unsigned REG_EVERY  = 2,
    parameter int unsigned TAG_LEN    = 5,
    localparam int unsigned SHAMT_LEN = shift_clog2(DATA_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_LEN-1:0]    in_op,
    input  logic                 in_word,
    input  logic [DATA_LEN-1:0]  in_data,
    input  logic [SHAMT_LEN-1:0] in_shamt,
    input  logic [TAG_LEN-1:0]   in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_LEN-1:0]  out_data,
    output logic [TAG_LEN-1:0]   out_tag
);

    localparam int unsigned NLEV = SHAMT_LEN;
    localparam int unsigned LAT  = shift_lat(DATA_LEN, REG_EVERY);

    logic [DATA_LEN-1:0]  pre_data;
    logic [SHAMT_LEN-1:0] pre_shamt;
    logic [DATA_LEN-1:0]  post_data;

    // Stage registers
    logic [LAT-1:0]       st_valid;
    logic [DATA_LEN-1:0]  st_data  [LAT];
    logic [OP_LEN-1:0]    st_op    [LAT];
    logic                 st_word  [LAT];
    logic [SHAMT_LEN-1:0] st_shamt [LAT];
    logic [TAG_LEN-1:0]   st_tag   [LAT];

    // What feeds each stage: the request for stage 0, the previous slice otherwise
    logic [LAT-1:0]       src_valid;
    logic [DATA_LEN-1:0]  src_data  [LAT];
    logic [OP_LEN-1:0]    src_op    [LAT];
    logic                 src_word  [LAT];
    logic [SHAMT_LEN-1:0] src_shamt [LAT];
    logic [TAG_LEN-1:0]   src_tag   [LAT];
    logic [DATA_LEN-1:0]  nxt_data  [LAT];

    logic [LAT-1:0]       adv;
    logic [DATA_LEN-1:0]  lvl_in  [NLEV];
    logic [DATA_LEN-1:0]  lvl_out [NLEV];

    // Word-mode conditioning exists only for the 64-bit datapath
    if (DATA_LEN == 64) begin : g_word
        logic [WORD_LEN-1:0] word_res;

        always_comb begin
            pre_data  = in_data;
            pre_shamt = in_shamt;
            if (in_word && !op_reserved(in_op)) begin
                pre_shamt = SHAMT_LEN'(in_shamt[4:0]);
                case (in_op)
                    SHIFT_SRL: pre_data = {32'd0, in_data[31:0]};
                    SHIFT_SRA: pre_data = {{32{in_data[31]}}, in_data[31:0]};
                    SHIFT_ROL,
                    SHIFT_ROR: pre_data = {in_data[31:0], in_data[31:0]};
                    default:   pre_data = in_data;
                endcase
            end
        end

        // A word rotate-left of {w,w} leaves the 32-bit result in the upper half.
        always_comb begin
            word_res  = lvl_out[NLEV-1][31:0];
            post_data = lvl_out[NLEV-1];
            if (src_word[LAT-1] && !op_reserved(src_op[LAT-1])) begin
                if (src_op[LAT-1] == SHIFT_ROL) begin
                    word_res = lvl_out[NLEV-1][63:32];
                end
                post_data = {{32{word_res[31]}}, word_res};
            end
        end
    end else begin : g_no_word
        assign pre_data  = in_data;
        assign pre_shamt = in_shamt;
        assign post_data = lvl_out[NLEV-1];
    end

    for (genvar s = 0; s < LAT; s++) begin : g_src
        if (s == 0) begin : g_first
            assign src_valid[s] = in_valid && in_ready;
            assign src_data[s]  = pre_data;
            assign src_op[s]    = in_op;
            assign src_word[s]  = in_word;
            assign src_shamt[s] = pre_shamt;
            assign src_tag[s]   = in_tag;
        end else begin : g_next
            assign src_valid[s] = st_valid[s-1];
            assign src_data[s]  = st_data[s-1];
            assign src_op[s]    = st_op[s-1];
            assign src_word[s]  = st_word[s-1];
            assign src_shamt[s] = st_shamt[s-1];
            assign src_tag[s]   = st_tag[s-1];
        end

        if (s == LAT - 1) begin : g_last
            assign nxt_data[s] = post_data;
        end else begin : g_mid
            assign nxt_data[s] = lvl_out[(s + 1) * REG_EVERY - 1];
        end
    end

    // Level k shifts by 2^k under control of the stage that owns it.
    for (genvar k = 0; k < NLEV; k++) begin : g_lvl
        localparam int unsigned SRC = k / REG_EVERY;

        if (k % REG_EVERY == 0) begin : g_head
            assign lvl_in[k] = src_data[SRC];
        end else begin : g_chain
            assign lvl_in[k] = lvl_out[k-1];
        end

        shift_level #(
            .DATA_LEN  (DATA_LEN),
            .SHIFT_NUM (1 << k)
        ) u_level (
            .op       (src_op[SRC]),
            .en       (src_shamt[SRC][k]),
            .data     (lvl_in[k]),
            .result_c (lvl_out[k])
        );
    end

    // A stage may move when it is empty or its successor moves.
    always_comb begin
        adv          = '0;
        adv[LAT-1]   = out_ready || !st_valid[LAT-1];
        for (int i = int'(LAT) - 2; i >= 0; i--) begin
            adv[i] = !st_valid[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0] && !flush;

    // Flush drops valids only; payload is loaded solely for live entries so held data stays put.
    always_ff @(posedge clk) begin
        for (int s = 0; s < LAT; s++) begin
            if (!rst_n) begin
                st_valid[s] <= 1'b0;
                st_data[s]  <= '0;
                st_op[s]    <= '0;
                st_word[s]  <= 1'b0;
                st_shamt[s] <= '0;
                st_tag[s]   <= '0;
            end else begin
                if (flush) begin
                    st_valid[s] <= 1'b0;
                end else if (adv[s]) begin
                    st_valid[s] <= src_valid[s];
                end
                if (adv[s] && src_valid[s]) begin
                    st_data[s]  <= nxt_data[s];
                    st_op[s]    <= src_op[s];
                    st_word[s]  <= src_word[s];
                    st_shamt[s] <= src_shamt[s];
                    st_tag[s]   <= src_tag[s];
                end
            end
        end
    end

    assign out_valid = st_valid[LAT-1];
    assign out_data  = st_data[LAT-1];
    assign out_tag   = st_tag[LAT-1];

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter with valid/ready handshake; successor to the single-level fixed-amount shifter. Performs SLL/SRL/SRA/ROL/ROR by a variable amount over `log2(DATA_LEN)` cascaded shift levels, with a pipeline register inserted after every `REG_EVERY` levels. Supports RV64 word (`*W`) mode with sign-extended 32-bit results. It sits in the EXU between issue and writeback, alongside the ALU, and carries an opaque tag for result routing.

## Interface
- `DATA_LEN`, 64: operand width; power of two, ≥8; word mode only legal when 64.
- `REG_EVERY`, 2: shift levels per pipeline register; 1..log2(DATA_LEN).
- `TAG_LEN`, 5: sideband tag width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `flush`  in  1  drop all in-flight operations.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_op`  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
- `in_word`  in  1  32-bit word mode.
- `in_data`  in  DATA_LEN  operand.
- `in_shamt`  in  log2(DATA_LEN)  shift amount.
- `in_tag`  in  TAG_LEN  sideband, returned unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  DATA_LEN  result.
- `out_tag`  out  TAG_LEN  tag of the result.

## Operation
- Levels: level k shifts by 2^k when shamt bit k = 1; fill is 0 (SLL/SRL), the sign bit (SRA), or the wrapped bits (ROL/ROR).
- Reserved op: result = `in_data` unshifted; the tag still flows.
- Word mode, pre-conditioning at input:
  - shamt masked to 5 bits.
  - SRL: upper 32 bits zeroed.
  - SRA: upper 32 bits = bit 31.
  - ROL/ROR: operand = {low32, low32}.
  - SLL: unchanged.
- Word mode, post-selection before the final register:
  - ROL: result = upper 32.
  - All other ops: result = lower 32.
  - Result is then sign-extended from bit 31 to 64.
- Pipeline: `LAT = ceil(log2(DATA_LEN)/REG_EVERY)` register stages. Each stage holds valid, partial data, op, word, remaining shamt bits and tag.
- Flow control:
  - `adv[LAT-1] = out_ready || !valid[LAT-1]`.
  - `adv[i] = !valid[i] || adv[i+1]`.
  - `in_ready = adv[0] && !flush`.
  - Bubbles collapse.
  - A held stage keeps its data stable.
- `out_valid`/`out_data`/`out_tag` are driven directly from the last stage register. No combinational path from inputs to outputs.
- `flush`: every valid bit clears at the next edge. The `in_ready` low in the flush cycle ensures no new request is accepted that cycle. Data registers are not cleared.
- Reset (`rst_n` low at an edge): all valid bits 0, all data/tag registers 0. This takes precedence over `flush` and handshake.

## Timing
- Latency `LAT` cycles: request accepted in cycle 0 → `out_valid` in cycle `LAT` if not stalled. Default config: LAT = 3.
- Throughput: one result per cycle while `out_ready` = 1.
- Capacity: `LAT` in-flight operations.
- Full pipe with `out_ready` = 0: `in_ready` = 0 combinationally in the same cycle.
- Simultaneous output pop and input accept in the same cycle: both occur, and the pipe shifts by one.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_tag` = 0. `in_ready` = 1 in the first cycle after reset, unless `flush` is high.
- `out_valid` falls only after a handshake, flush or reset; it never retracts while `out_ready` = 0.

## Structure
- Shared package `shift_pkg` contains:
  - op encodings `SHIFT_SLL`..`SHIFT_ROR`;
  - a `clog2`-style function;
  - a `LAT` computation used by both RTL and bench.
- Sub-module `shift_level`: one combinational level with parameters `DATA_LEN` and `SHIFT_NUM`, and inputs `op` and `en`.
  - It is instantiated once per bit of shamt in a generate loop.
  - A register slice is generated after every `REG_EVERY` levels and after the final level.
- Top: pre-conditioning, level chain, post-selection, and the valid/adv control.

## Test plan
All scenarios use DATA_LEN = 64, REG_EVERY = 2, LAT = 3.
- SLL, data 0x1, shamt 63 → `out_data` 0x8000_0000_0000_0000 in cycle 3, tag preserved.
- SRA and SRL, data 0x8000_0000_0000_0000, shamt 4 → 0xF800_0000_0000_0000 and 0x0800_0000_0000_0000 respectively.
- ROR, data 0xFF, shamt 8 → 0xFF00_0000_0000_0000.
- Word mode:
  - ROLW, data 0x8000_0001, shamt 1 → 0x3.
  - SRAW, data 0x8000_0000, shamt 36 → 0xFFFF_FFFF_F800_0000.
  - SLLW, data 0x4000_0000, shamt 1 → 0xFFFF_FFFF_8000_0000.
  - Reserved op 111, data 0x1234 → 0x1234.
- Backpressure: issue tags 0..7 back-to-back, `out_ready` = 0 in cycles 4..7.
  - `in_ready` drops once 3 ops are held.
  - Tags emerge as 0..7 in order, no loss or duplication.
  - Throughput is 1/cycle after release.
- Flush with 2 ops in flight and `in_valid` = 1: `in_ready` = 0 that cycle; next cycle `out_valid` = 0; no flushed tag ever appears. Then reset (`rst_n` low 1 cycle) with a full pipe: `out_valid`/`out_data`/`out_tag` = 0 the next cycle.
